// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like memory port between instruction fetch and data access
// Ports: inst_sram_* / data_sram_* requester sides, mem_* downstream port,
//        outst_cnt (accepted-but-unanswered transactions), arb_err (sticky stray-response flag).
// Data wins arbitration unless inst has waited through STARVE_LIMIT data grants; a stalled
// address phase locks its grant until accepted or withdrawn. A 1-bit source FIFO routes the
// in-order responses back to whichever side issued each accepted request.
module sram_port_arbiter #(
  parameter int OUTST_DEPTH  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inst_sram_req,
  input  logic                           inst_sram_wr,
  input  logic [1:0]                     inst_sram_size,
  input  logic [3:0]                     inst_sram_wstrb,
  input  logic [31:0]                    inst_sram_addr,
  input  logic [31:0]                    inst_sram_wdata,
  output logic                           inst_sram_addr_ok,
  output logic                           inst_sram_data_ok,
  output logic [31:0]                    inst_sram_rdata,
  input  logic                           data_sram_req,
  input  logic                           data_sram_wr,
  input  logic [1:0]                     data_sram_size,
  input  logic [3:0]                     data_sram_wstrb,
  input  logic [31:0]                    data_sram_addr,
  input  logic [31:0]                    data_sram_wdata,
  output logic                           data_sram_addr_ok,
  output logic                           data_sram_data_ok,
  output logic [31:0]                    data_sram_rdata,
  output logic                           mem_req,
  output logic                           mem_wr,
  output logic [1:0]                     mem_size,
  output logic [3:0]                     mem_wstrb,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic                           mem_addr_ok,
  input  logic                           mem_data_ok,
  input  logic [31:0]                    mem_rdata,
  output logic [$clog2(OUTST_DEPTH):0]   outst_cnt,
  output logic                           arb_err
);
  localparam int AW = $clog2(OUTST_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = OUTST_DEPTH[AW:0];
  localparam logic [SW-1:0] LIMIT_C = STARVE_LIMIT[SW-1:0];
  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;
  state_t state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic [OUTST_DEPTH-1:0] src_q;
  logic [AW-1:0] wptr, rptr;
  logic full, empty, sel_d, sel_req, accept, pop, head;
  assign full  = outst_cnt == DEPTH_C;
  assign empty = outst_cnt == '0;
  assign head  = src_q[rptr];
  // sel_d picks the requester whose fields drive the port; held in HOLD_* states
  always_comb begin
    sel_d    = state == HOLD_D ? 1'b1 :
               state == HOLD_I ? 1'b0 :
               data_sram_req & ~(inst_sram_req & starve_cnt == LIMIT_C);
    state_nx = state == IDLE ? ((mem_req & ~mem_addr_ok) ? (sel_d ? HOLD_D : HOLD_I) : IDLE) :
               (accept | ~sel_req) ? IDLE : state;
  end
  assign sel_req   = sel_d ? data_sram_req : inst_sram_req;
  // reset also masks the combinational handshakes so nothing escapes while it is held
  assign mem_req   = sel_req & ~full & ~reset;
  assign accept    = mem_req & mem_addr_ok;
  assign pop       = mem_data_ok & ~empty & ~reset;
  assign mem_wr    = mem_req & (sel_d ? data_sram_wr : inst_sram_wr);
  assign mem_size  = mem_req ? (sel_d ? data_sram_size  : inst_sram_size)  : '0;
  assign mem_wstrb = mem_req ? (sel_d ? data_sram_wstrb : inst_sram_wstrb) : '0;
  assign mem_addr  = mem_req ? (sel_d ? data_sram_addr  : inst_sram_addr)  : '0;
  assign mem_wdata = mem_req ? (sel_d ? data_sram_wdata : inst_sram_wdata) : '0;
  assign inst_sram_addr_ok = accept & ~sel_d;
  assign data_sram_addr_ok = accept & sel_d;
  assign inst_sram_data_ok = pop & ~head;
  assign data_sram_data_ok = pop & head;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wptr       <= '0;
      rptr       <= '0;
      outst_cnt  <= '0;
      arb_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= (~inst_sram_req | (accept & ~sel_d)) ? '0 :
                    (accept & starve_cnt != LIMIT_C) ? starve_cnt + 1'b1 : starve_cnt;
      if (accept) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      outst_cnt  <= outst_cnt + (AW+1)'(accept) - (AW+1)'(pop);
      if (mem_data_ok & empty) arb_err <= 1'b1;
    end
  end
  // source tags need no reset: entries are only read between their push and pop
  always_ff @(posedge clk) begin
    if (accept) src_q[wptr] <= sel_d;
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector-table and directed-sequence bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam logic [31:0] IA = 32'h1C00_0000, DA = 32'h8000_1000;
  localparam logic [31:0] IW = 32'h1111_1111, DW = 32'h2222_2222;
  logic clk = 1'b0, reset = 1'b1;
  logic inst_sram_req = 0, data_sram_req = 0, mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  logic inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic mem_req, mem_wr;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0] outst_cnt;
  logic arb_err;
  int checks = 0, errors = 0, cur = -1;
  typedef struct {
    logic ir, dr, aok, dok;
    logic [31:0] rd;
    logic mreq;
    logic [31:0] ma;
    logic iaok, daok, idok, ddok;
    logic [2:0] cnt;
    logic err;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  sram_port_arbiter #(.OUTST_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(1'b0), .inst_sram_size(2'd2),
    .inst_sram_wstrb(4'hF), .inst_sram_addr(IA), .inst_sram_wdata(IW),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(1'b1), .data_sram_size(2'd1),
    .data_sram_wstrb(4'h3), .data_sram_addr(DA), .data_sram_wdata(DW),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outst_cnt(outst_cnt), .arb_err(arb_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask
  task automatic add(input logic ir, dr, aok, dok, input logic [31:0] rd, input logic mreq,
                     input logic [31:0] ma, input logic iaok, daok, idok, ddok,
                     input logic [2:0] cnt, input logic err);
    tv.push_back('{ir, dr, aok, dok, rd, mreq, ma, iaok, daok, idok, ddok, cnt, err});
  endtask
  task automatic idle(input logic [2:0] cnt, input logic err);
    add(0,0,0,0,0, 0,0,0,0,0,0, cnt, err);
  endtask
  initial begin
    // single inst read
    idle(0,0);
    add(1,0,1,0,0,           1,IA,1,0,0,0, 0,0);
    idle(1,0);
    add(0,0,0,1,32'hDEADBEEF, 0,0,0,0,1,0, 1,0);
    idle(0,0);
    // interleaved routing I,D,D,I
    add(1,0,1,0,0, 1,IA,1,0,0,0, 0,0);
    add(0,1,1,0,0, 1,DA,0,1,0,0, 1,0);
    add(0,1,1,0,0, 1,DA,0,1,0,0, 2,0);
    add(1,0,1,0,0, 1,IA,1,0,0,0, 3,0);
    add(0,0,0,1,1, 0,0,0,0,1,0, 4,0);
    add(0,0,0,1,2, 0,0,0,0,0,1, 3,0);
    add(0,0,0,1,3, 0,0,0,0,0,1, 2,0);
    add(0,0,0,1,4, 0,0,0,0,1,0, 1,0);
    idle(0,0);
    // starvation: D,D,D,D,I,D,D,D,D,I with one-cycle-later responses
    add(1,1,1,0,0,  1,DA,0,1,0,0, 0,0);
    add(1,1,1,1,10, 1,DA,0,1,0,1, 1,0);
    add(1,1,1,1,11, 1,DA,0,1,0,1, 1,0);
    add(1,1,1,1,12, 1,DA,0,1,0,1, 1,0);
    add(1,1,1,1,13, 1,IA,1,0,0,1, 1,0);
    add(1,1,1,1,14, 1,DA,0,1,1,0, 1,0);
    add(1,1,1,1,15, 1,DA,0,1,0,1, 1,0);
    add(1,1,1,1,16, 1,DA,0,1,0,1, 1,0);
    add(1,1,1,1,17, 1,DA,0,1,0,1, 1,0);
    add(1,1,1,1,18, 1,IA,1,0,0,1, 1,0);
    add(0,0,0,1,19, 0,0,0,0,1,0, 1,0);
    idle(0,0);
    // simultaneous requests, address phase stalled 3 cycles
    add(1,1,0,0,0, 1,DA,0,0,0,0, 0,0);
    add(1,1,0,0,0, 1,DA,0,0,0,0, 0,0);
    add(1,1,0,0,0, 1,DA,0,0,0,0, 0,0);
    add(1,1,1,0,0, 1,DA,0,1,0,0, 0,0);
    add(1,0,1,0,0, 1,IA,1,0,0,0, 1,0);
    add(0,0,0,1,5, 0,0,0,0,0,1, 2,0);
    add(0,0,0,1,6, 0,0,0,0,1,0, 1,0);
    idle(0,0);
    // held data request withdrawn: no push, inst then granted
    add(1,1,0,0,0, 1,DA,0,0,0,0, 0,0);
    add(1,1,0,0,0, 1,DA,0,0,0,0, 0,0);
    add(1,0,0,0,0, 0,0,0,0,0,0,  0,0);
    add(1,0,1,0,0, 1,IA,1,0,0,0, 0,0);
    add(0,0,0,1,7, 0,0,0,0,1,0, 1,0);
    idle(0,0);
    // full FIFO, refill on pop, push+pop with pointer wrap
    add(0,1,1,0,0, 1,DA,0,1,0,0, 0,0);
    add(0,1,1,0,0, 1,DA,0,1,0,0, 1,0);
    add(0,1,1,0,0, 1,DA,0,1,0,0, 2,0);
    add(0,1,1,0,0, 1,DA,0,1,0,0, 3,0);
    add(0,1,1,0,0, 0,0,0,0,0,0,  4,0);
    add(0,1,1,1,8, 0,0,0,0,0,1,  4,0);
    add(0,1,1,1,9, 1,DA,0,1,0,1, 3,0);
    add(1,0,1,1,10,1,IA,1,0,0,1, 3,0);
    add(0,0,0,1,11,0,0,0,0,0,1,  3,0);
    add(0,0,0,1,12,0,0,0,0,0,1,  2,0);
    add(0,0,0,1,13,0,0,0,0,1,0,  1,0);
    // stray response while empty
    add(0,0,0,1,14,0,0,0,0,0,0,  0,0);
    idle(0,1);
    add(0,0,0,1,15,0,0,0,0,0,0,  0,1);
    idle(0,1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (tv[i]) begin
      @(negedge clk);
      cur = i;
      inst_sram_req = tv[i].ir; data_sram_req = tv[i].dr;
      mem_addr_ok = tv[i].aok; mem_data_ok = tv[i].dok; mem_rdata = tv[i].rd;
      #1;
      chk("mem_req",   32'(mem_req),   32'(tv[i].mreq));
      chk("mem_addr",  mem_addr,       tv[i].ma);
      chk("mem_wdata", mem_wdata,      tv[i].ma == IA ? IW : tv[i].ma == DA ? DW : 32'h0);
      chk("mem_wr",    32'(mem_wr),    32'(tv[i].ma == DA));
      chk("mem_wstrb", 32'(mem_wstrb), tv[i].ma == IA ? 32'hF : tv[i].ma == DA ? 32'h3 : 32'h0);
      chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(tv[i].iaok));
      chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(tv[i].daok));
      chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(tv[i].idok));
      chk("data_data_ok", 32'(data_sram_data_ok), 32'(tv[i].ddok));
      chk("outst_cnt", 32'(outst_cnt), 32'(tv[i].cnt));
      chk("arb_err",   32'(arb_err),   32'(tv[i].err));
      if (tv[i].dok) begin
        chk("inst_rdata", inst_sram_rdata, tv[i].rd);
        chk("data_rdata", data_sram_rdata, tv[i].rd);
      end
    end
    // asynchronous reset with two transactions outstanding
    cur = -1;
    @(negedge clk);
    inst_sram_req = 1; data_sram_req = 0; mem_addr_ok = 1; mem_data_ok = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_cnt", 32'(outst_cnt), 32'd2);
    chk("pre_reset_err", 32'(arb_err), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("reset_cnt",     32'(outst_cnt), 32'd0);
    chk("reset_err",     32'(arb_err), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    @(negedge clk);
    reset = 1'b0; inst_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    chk("late_inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("late_data_data_ok", 32'(data_sram_data_ok), 32'd0);
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    chk("late_err", 32'(arb_err), 32'd1);
    chk("late_cnt", 32'(outst_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one downstream SRAM-like memory port between the instruction-fetch requester and the EXE-stage data requester.
- Serializes address phases with data-first priority and an anti-starvation limit, holds a grant until the address handshake completes, and tracks outstanding transactions in a source-ID FIFO so in-order responses are routed back to the correct requester.
- Sits between the pipeline SRAM-like interfaces and the AXI bridge.

Parameters:
- OUTST_DEPTH, 4, maximum accepted-but-unanswered transactions (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_sram_req is pending before inst is forced a grant.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- inst_sram_req / inst_sram_wr  in  1 / 1  instruction request; wr is normally 0.
- inst_sram_size  in  2  transfer size.
- inst_sram_wstrb  in  4  byte strobes.
- inst_sram_addr / inst_sram_wdata  in  32 / 32  address and write data.
- inst_sram_addr_ok / inst_sram_data_ok  out  1 / 1  address accepted / response valid.
- inst_sram_rdata  out  32  read data.
- data_sram_req / wr / size / wstrb / addr / wdata  in  1/1/2/4/32/32  data request, same fields as inst.
- data_sram_addr_ok / data_sram_data_ok / data_sram_rdata  out  1/1/32  same meaning as inst.
- mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/4/32/32  downstream request.
- mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  downstream handshakes and read data.
- outst_cnt  out  log2(OUTST_DEPTH)+1  current outstanding count.
- arb_err  out  1  sticky protocol error flag.

Behaviour:
- Reset asserted (async): FIFO empty, outst_cnt=0, lock state IDLE, starve counter 0, arb_err=0.
  - Combinational outputs then give mem_req=0, all *_addr_ok=0, all *_data_ok=0.
- full = (outst_cnt==OUTST_DEPTH).
- When full: mem_req=0 and no addr_ok is issued.
- Lock FSM, states IDLE, HOLD_I, HOLD_D:
  - IDLE: grant selection.
    - grant=D if data_sram_req and not (inst_sram_req and starve_cnt==STARVE_LIMIT).
    - Otherwise grant=I if inst_sram_req.
  - mem_req = granted req & ~full.
  - If mem_req & ~mem_addr_ok, go to HOLD_<grant>.
  - HOLD_X: grant fixed to X regardless of the other requester.
    - mem_addr_ok → IDLE.
    - X's req drops (flush) → IDLE, no push.
- Request muxing: mem_wr/size/wstrb/addr/wdata are taken from the granted requester, else zero.
- addr_ok routing: <grant>_sram_addr_ok = mem_addr_ok & mem_req. The non-granted addr_ok is always 0.
- Starve counter:
  - Increments on an accepted data transfer while inst_sram_req=1, saturating at STARVE_LIMIT.
  - Clears on an accepted inst transfer, or any cycle inst_sram_req=0.
- Source FIFO, depth OUTST_DEPTH, 1-bit entries (0=inst, 1=data):
  - Push the grant ID on mem_req & mem_addr_ok.
  - Pop on mem_data_ok.
  - Push and pop in the same cycle: count unchanged, both pointers advance (wrap modulo depth).
- Response routing:
  - inst_sram_data_ok = mem_data_ok & ~empty & head==0.
  - data_sram_data_ok = mem_data_ok & ~empty & head==1.
  - mem_rdata is broadcast to both rdata outputs unchanged.
- Responses arrive in order; zero-latency data_ok (same cycle as addr_ok) is not required to be supported. Response cycle ≥1 after acceptance.
- mem_data_ok while empty: ignored (no data_ok to either requester), arb_err set to 1 and held until reset.
- Latency: zero-cycle combinational pass-through of request and response; no added pipeline stage.
- Reset mid-transaction: FIFO and lock are discarded immediately; late mem_data_ok after reset sets arb_err. Downstream is reset together with this block.

Test Plan:
- Single inst read: inst_sram_req=1, addr=0x1C000000, mem_addr_ok=1 same cycle, mem_data_ok two cycles later with rdata=0xDEADBEEF → inst_sram_addr_ok=1 in cycle 0, inst_sram_data_ok=1 with rdata 0xDEADBEEF, data_sram_data_ok=0, outst_cnt 1→0.
- Simultaneous requests: both req=1, mem_addr_ok held 0 for 3 cycles then 1 → mem_addr = data addr for all 4 cycles (HOLD_D), then inst is granted next cycle.
  - Repeat with data dropping req during cycle 2 → FSM returns to IDLE, inst is granted, no FIFO push.
- Starvation: data_sram_req and inst_sram_req held 1, mem_addr_ok=1 every cycle, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Full FIFO: OUTST_DEPTH=4, issue 4 accepted data reads with no data_ok → outst_cnt=4, mem_req=0 on the 5th request.
  - One mem_data_ok → cnt=3, 5th request is accepted next cycle.
  - Simultaneous push/pop keeps cnt=3 with correct wrap routing.
- Interleaved routing: accept I,D,D,I, return 4 data_ok with rdata 1,2,3,4 → inst gets 1 and 4, data gets 2 and 3.
- Error/reset: mem_data_ok with empty FIFO → arb_err=1 sticky, no requester data_ok; assert reset with 2 outstanding → outst_cnt=0 and arb_err=0 asynchronously.
